// File: rtl/axis_frame_fifo_if.sv
// AXI4-Stream bundle shared by the slave and master sides of axis_frame_fifo.
interface axis_frame_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_frame_fifo.sv
// AXI4-Stream FIFO: 2^ADDR_WIDTH-word RAM plus a one-word output register,
// with an optional store-and-forward frame mode that drops overflowing or
// bad frames as a whole.
module axis_frame_fifo #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter bit LAST_ENABLE = 1'b1,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1,
  parameter bit FRAME_FIFO  = 1'b0,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
  parameter bit DROP_BAD_FRAME = 1'b0,
  parameter bit DROP_WHEN_FULL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  axis_frame_fifo_if.slave  s_axis,
  axis_frame_fifo_if.master m_axis,
  output logic             status_overflow,
  output logic             status_bad_frame,
  output logic             status_good_frame
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int KEEP_OFF = DATA_WIDTH;
  localparam int LAST_OFF = KEEP_OFF + (KEEP_ENABLE ? KEEP_WIDTH : 0);
  localparam int ID_OFF   = LAST_OFF + (LAST_ENABLE ? 1 : 0);
  localparam int DEST_OFF = ID_OFF + (ID_ENABLE ? ID_WIDTH : 0);
  localparam int USER_OFF = DEST_OFF + (DEST_ENABLE ? DEST_WIDTH : 0);
  localparam int WORD_W   = USER_OFF + (USER_ENABLE ? USER_WIDTH : 0);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_cur;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                drop_frame;

  logic full, full_cur, empty;
  logic s_ready, s_last, bad_frame, wr_accept, discard, ram_we, rd_en;

  logic [WORD_W-1:0] s_word;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] out_word_p1;
  logic              out_vld_p1;

  // Optional sideband inputs that a given build may not store.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis.tkeep, s_axis.tlast, s_axis.tid, s_axis.tdest, s_axis.tuser};

  assign full     = (wr_ptr     == {~rd_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH-1:0]});
  assign full_cur = (wr_ptr_cur == {~rd_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH-1:0]});
  assign empty    = (wr_ptr == rd_ptr);

  assign s_ready   = FRAME_FIFO ? (!full_cur || DROP_WHEN_FULL) : !full;
  assign s_last    = LAST_ENABLE ? s_axis.tlast : 1'b1;
  assign bad_frame = USER_ENABLE &&
                     ((s_axis.tuser & USER_BAD_FRAME_MASK) ==
                      (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));
  assign wr_accept = s_axis.tvalid && s_ready;
  // In frame mode a beat is thrown away once the frame has overflowed.
  assign discard   = FRAME_FIFO && (full_cur || drop_frame);
  assign ram_we    = wr_accept && !discard;
  assign rd_en     = !empty && (!out_vld_p1 || m_axis.tready);

  assign s_axis.tready = s_ready;

  // RAM word packing: data first, then each enabled sideband field.
  assign s_word[DATA_WIDTH-1:0] = s_axis.tdata;
  if (KEEP_ENABLE) begin : g_keep_in
    assign s_word[KEEP_OFF +: KEEP_WIDTH] = s_axis.tkeep;
  end
  if (LAST_ENABLE) begin : g_last_in
    assign s_word[LAST_OFF] = s_axis.tlast;
  end
  if (ID_ENABLE) begin : g_id_in
    assign s_word[ID_OFF +: ID_WIDTH] = s_axis.tid;
  end
  if (DEST_ENABLE) begin : g_dest_in
    assign s_word[DEST_OFF +: DEST_WIDTH] = s_axis.tdest;
  end
  if (USER_ENABLE) begin : g_user_in
    assign s_word[USER_OFF +: USER_WIDTH] = s_axis.tuser;
  end

  // Output unpacking; fields not stored drive their fixed values.
  assign m_axis.tvalid = out_vld_p1;
  assign m_axis.tdata  = out_word_p1[DATA_WIDTH-1:0];
  if (KEEP_ENABLE) begin : g_keep_out
    assign m_axis.tkeep = out_word_p1[KEEP_OFF +: KEEP_WIDTH];
  end else begin : g_keep_fix
    assign m_axis.tkeep = '1;
  end
  if (LAST_ENABLE) begin : g_last_out
    assign m_axis.tlast = out_word_p1[LAST_OFF];
  end else begin : g_last_fix
    assign m_axis.tlast = 1'b1;
  end
  if (ID_ENABLE) begin : g_id_out
    assign m_axis.tid = out_word_p1[ID_OFF +: ID_WIDTH];
  end else begin : g_id_fix
    assign m_axis.tid = '0;
  end
  if (DEST_ENABLE) begin : g_dest_out
    assign m_axis.tdest = out_word_p1[DEST_OFF +: DEST_WIDTH];
  end else begin : g_dest_fix
    assign m_axis.tdest = '0;
  end
  if (USER_ENABLE) begin : g_user_out
    assign m_axis.tuser = out_word_p1[USER_OFF +: USER_WIDTH];
  end else begin : g_user_fix
    assign m_axis.tuser = '0;
  end

  // Write stage: store accepted beats at the speculative write pointer.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= s_word;
    end
  end

  // Write-side pointers, overflow tracking and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr            <= '0;
      wr_ptr_cur        <= '0;
      drop_frame        <= 1'b0;
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
      if (!FRAME_FIFO) begin
        if (wr_accept) begin
          wr_ptr     <= wr_ptr + 1'b1;
          wr_ptr_cur <= wr_ptr + 1'b1;
        end
      end else if (wr_accept) begin
        if (discard) begin
          drop_frame <= 1'b1;
          if (s_last) begin
            // Rewind over the whole frame, including beats stored before it overflowed.
            wr_ptr_cur      <= wr_ptr;
            drop_frame      <= 1'b0;
            status_overflow <= 1'b1;
          end
        end else begin
          wr_ptr_cur <= wr_ptr_cur + 1'b1;
          if (s_last) begin
            if (DROP_BAD_FRAME && bad_frame) begin
              wr_ptr_cur       <= wr_ptr;
              status_bad_frame <= 1'b1;
            end else begin
              wr_ptr            <= wr_ptr_cur + 1'b1;
              status_good_frame <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Read stage: refill the output register whenever it is free or being taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr     <= '0;
      out_vld_p1 <= 1'b0;
    end else if (rd_en) begin
      rd_ptr     <= rd_ptr + 1'b1;
      out_vld_p1 <= 1'b1;
    end else if (m_axis.tready) begin
      out_vld_p1 <= 1'b0;
    end
  end

  // Output data register; cleared on reset so the idle bus reads as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_word_p1 <= '0;
    end else if (rd_en) begin
      out_word_p1 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Bench for axis_frame_fifo: a 4-word non-frame instance and a 4-word frame
// instance (drop-when-full, drop-bad-frame), directed steps plus random
// traffic checked against queue-based expectations.
module tb_axis_frame_fifo;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axis_frame_fifo_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) s_nf ();
  axis_frame_fifo_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) m_nf ();
  axis_frame_fifo_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) s_fr ();
  axis_frame_fifo_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) m_fr ();

  logic ovf_nf, bad_nf, good_nf, ovf_fr, bad_fr, good_fr;

  axis_frame_fifo #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FRAME_FIFO(1'b0)) u_nf (
    .clk(clk), .rst(rst), .s_axis(s_nf), .m_axis(m_nf),
    .status_overflow(ovf_nf), .status_bad_frame(bad_nf), .status_good_frame(good_nf)
  );

  axis_frame_fifo #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FRAME_FIFO(1'b1),
                    .DROP_BAD_FRAME(1'b1), .DROP_WHEN_FULL(1'b1)) u_fr (
    .clk(clk), .rst(rst), .s_axis(s_fr), .m_axis(m_fr),
    .status_overflow(ovf_fr), .status_bad_frame(bad_fr), .status_good_frame(good_fr)
  );

  // Output beats as {tuser, tlast, tdata}, plus the cycle each was taken.
  logic [9:0] nf_out[$];
  int         nf_t[$];
  logic [9:0] fr_out[$];
  int ovf_cnt = 0, bad_cnt = 0, good_cnt = 0;

  always @(negedge clk) begin
    if (m_nf.tvalid === 1'b1 && m_nf.tready === 1'b1) begin
      nf_out.push_back({m_nf.tuser, m_nf.tlast, m_nf.tdata});
      nf_t.push_back(cyc);
    end
    if (m_fr.tvalid === 1'b1 && m_fr.tready === 1'b1)
      fr_out.push_back({m_fr.tuser, m_fr.tlast, m_fr.tdata});
  end

  always @(negedge clk) begin
    if (ovf_fr === 1'b1) ovf_cnt <= ovf_cnt + 1;
    if (bad_fr === 1'b1) bad_cnt <= bad_cnt + 1;
    if (good_fr === 1'b1) good_cnt <= good_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nf(input logic [7:0] d, input logic l, input logic u);
    logic acc;
    acc = 1'b0;
    s_nf.tdata = d; s_nf.tlast = l; s_nf.tuser = u; s_nf.tvalid = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      acc = s_nf.tready;
      tick();
    end
    s_nf.tvalid = 1'b0;
    check("nf_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_fr(input logic [7:0] d, input logic l, input logic u);
    logic acc;
    acc = 1'b0;
    s_fr.tdata = d; s_fr.tlast = l; s_fr.tuser = u; s_fr.tvalid = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      acc = s_fr.tready;
      tick();
    end
    s_fr.tvalid = 1'b0;
    check("fr_accept", 32'(acc), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base2, ovf0, bad0, good0, acc_n, consumed, ram_words, leaks, nbad, ngood, len;
    logic acc, isbad, l, u;
    logic [7:0] d;
    logic [9:0] exp_nf[$];
    logic [9:0] exp_fr[$];
    logic [9:0] frame[$];

    s_nf.tvalid = 1'b0; s_nf.tdata = '0; s_nf.tlast = 1'b0; s_nf.tuser = 1'b0;
    s_nf.tkeep = '1; s_nf.tid = '0; s_nf.tdest = '0;
    s_fr.tvalid = 1'b0; s_fr.tdata = '0; s_fr.tlast = 1'b0; s_fr.tuser = 1'b0;
    s_fr.tkeep = '1; s_fr.tid = '0; s_fr.tdest = '0;
    m_nf.tready = 1'b0;
    m_fr.tready = 1'b0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;

    // Reset state
    check("rst_nf_tvalid", 32'(m_nf.tvalid), 32'd0);
    check("rst_fr_tvalid", 32'(m_fr.tvalid), 32'd0);
    check("rst_nf_tready", 32'(s_nf.tready), 32'd1);
    check("rst_fr_tready", 32'(s_fr.tready), 32'd1);
    check("rst_nf_tdata", 32'(m_nf.tdata), 32'd0);
    check("rst_status", 32'({ovf_fr, bad_fr, good_fr, ovf_nf, bad_nf}), 32'd0);

    // Non-frame: write 0..3 while blocked, then drain back to back
    base = nf_out.size();
    send_nf(8'd0, 1'b0, 1'b0);
    check("nf_lat_before", 32'(m_nf.tvalid), 32'd0);
    send_nf(8'd1, 1'b0, 1'b0);
    check("nf_lat_valid", 32'(m_nf.tvalid), 32'd1);
    check("nf_lat_data", 32'(m_nf.tdata), 32'd0);
    send_nf(8'd2, 1'b0, 1'b0);
    send_nf(8'd3, 1'b1, 1'b0);
    m_nf.tready = 1'b1;
    for (int n = 0; n < 20 && nf_out.size() < base + 4; n++) tick();
    check("nf_seq_count", 32'(nf_out.size() - base), 32'd4);
    for (int i = 0; i < 4 && base + i < nf_out.size(); i++) begin
      check("nf_seq_beat", 32'(nf_out[base+i]), 32'({1'b0, (i == 3), 8'(i)}));
      check("nf_seq_nogap", 32'(nf_t[base+i] - nf_t[base]), 32'(i));
    end
    tick();
    check("nf_seq_idle", 32'(m_nf.tvalid), 32'd0);
    m_nf.tready = 1'b0;

    // Non-frame: 4 RAM words + output register, then one read frees a slot
    base = nf_out.size();
    for (int i = 0; i < 5; i++) begin
      send_nf(8'(8'h10 + i), 1'(i == 4), 1'b0);
      check("nf_fill_tready", 32'(s_nf.tready), 32'(i < 4));
    end
    m_nf.tready = 1'b1;
    tick();
    m_nf.tready = 1'b0;
    check("nf_fill_recover", 32'(s_nf.tready), 32'd1);
    check("nf_fill_one_read", 32'(nf_out.size() - base), 32'd1);
    m_nf.tready = 1'b1;
    for (int n = 0; n < 20 && nf_out.size() < base + 5; n++) tick();
    check("nf_fill_count", 32'(nf_out.size() - base), 32'd5);
    for (int i = 0; i < 5 && base + i < nf_out.size(); i++)
      check("nf_fill_beat", 32'(nf_out[base+i]), 32'({1'b0, (i == 4), 8'(8'h10 + i)}));
    tick();

    // Non-frame random traffic against a queue and an occupancy count
    base = nf_out.size();
    acc_n = 0;
    for (int c = 0; c < 400; c++) begin
      if (!s_nf.tvalid && $urandom_range(0, 2) != 0) begin
        s_nf.tvalid = 1'b1;
        s_nf.tdata = 8'($urandom);
        s_nf.tlast = 1'($urandom);
        s_nf.tuser = 1'($urandom);
      end
      m_nf.tready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      acc = s_nf.tvalid && s_nf.tready;
      if (acc) exp_nf.push_back({s_nf.tuser, s_nf.tlast, s_nf.tdata});
      tick();
      if (acc) begin
        acc_n++;
        s_nf.tvalid = 1'b0;
      end
      consumed = nf_out.size() - base;
      ram_words = acc_n - consumed - int'(m_nf.tvalid);
      check("nf_rand_tready", 32'(s_nf.tready), 32'(ram_words != 4));
    end
    s_nf.tvalid = 1'b0;
    m_nf.tready = 1'b1;
    for (int n = 0; n < 50 && nf_out.size() < base + exp_nf.size(); n++) tick();
    check("nf_rand_count", 32'(nf_out.size() - base), 32'(exp_nf.size()));
    for (int i = 0; i < exp_nf.size() && base + i < nf_out.size(); i++)
      check("nf_rand_beat", 32'(nf_out[base+i]), 32'(exp_nf[i]));

    // Frame mode: four frames fill the RAM, an overflowing frame is dropped whole
    base = fr_out.size();
    ovf0 = ovf_cnt; bad0 = bad_cnt; good0 = good_cnt;
    m_fr.tready = 1'b0;
    send_fr(8'd1, 1'b1, 1'b0);
    send_fr(8'd1, 1'b1, 1'b0);
    send_fr(8'd2, 1'b1, 1'b0);
    send_fr(8'd3, 1'b1, 1'b0);
    send_fr(8'd4, 1'b0, 1'b0);
    send_fr(8'd5, 1'b0, 1'b0);
    send_fr(8'd6, 1'b0, 1'b0);
    check("fr_ovf_tready", 32'(s_fr.tready), 32'd1);
    m_fr.tready = 1'b1;
    send_fr(8'd7, 1'b0, 1'b0);
    send_fr(8'd8, 1'b1, 1'b0);
    for (int n = 0; n < 12; n++) tick();
    check("fr_ovf_count", 32'(fr_out.size() - base), 32'd4);
    for (int i = 0; i < 4 && base + i < fr_out.size(); i++)
      check("fr_ovf_beat", 32'(fr_out[base+i]), 32'({1'b0, 1'b1, 8'((i == 0) ? 1 : i)}));
    leaks = 0;
    for (int i = base; i < fr_out.size(); i++)
      if (fr_out[i][7:0] >= 8'd4 && fr_out[i][7:0] <= 8'd8) leaks++;
    check("fr_ovf_noleak", 32'(leaks), 32'd0);
    check("fr_ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);
    check("fr_ovf_good", 32'(good_cnt - good0), 32'd4);
    check("fr_ovf_bad", 32'(bad_cnt - bad0), 32'd0);
    check("fr_ovf_idle", 32'(m_fr.tvalid), 32'd0);

    // Frame mode: nothing visible until tlast
    base = fr_out.size();
    good0 = good_cnt;
    send_fr(8'h21, 1'b0, 1'b0);
    send_fr(8'h22, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("fr_hold_tvalid", 32'(m_fr.tvalid), 32'd0);
    end
    send_fr(8'h23, 1'b1, 1'b0);
    check("fr_hold_good_pulse", 32'(good_fr), 32'd1);
    check("fr_hold_not_yet", 32'(m_fr.tvalid), 32'd0);
    tick();
    check("fr_hold_good_end", 32'(good_fr), 32'd0);
    check("fr_hold_first_valid", 32'(m_fr.tvalid), 32'd1);
    check("fr_hold_first_data", 32'(m_fr.tdata), 32'h21);
    for (int n = 0; n < 6; n++) tick();
    check("fr_hold_count", 32'(fr_out.size() - base), 32'd3);
    for (int i = 0; i < 3 && base + i < fr_out.size(); i++)
      check("fr_hold_beat", 32'(fr_out[base+i]), 32'({1'b0, (i == 2), 8'(8'h21 + i)}));
    check("fr_hold_good_once", 32'(good_cnt - good0), 32'd1);

    // Frame mode: bad frame dropped, following good frame passes
    base = fr_out.size();
    bad0 = bad_cnt;
    send_fr(8'h31, 1'b0, 1'b0);
    send_fr(8'h32, 1'b1, 1'b1);
    check("fr_bad_pulse", 32'(bad_fr), 32'd1);
    check("fr_bad_no_good", 32'(good_fr), 32'd0);
    tick();
    check("fr_bad_pulse_end", 32'(bad_fr), 32'd0);
    for (int n = 0; n < 5; n++) tick();
    check("fr_bad_no_output", 32'(fr_out.size() - base), 32'd0);
    send_fr(8'h41, 1'b0, 1'b1);
    send_fr(8'h42, 1'b1, 1'b0);
    check("fr_after_bad_good", 32'(good_fr), 32'd1);
    for (int n = 0; n < 6; n++) tick();
    check("fr_after_bad_count", 32'(fr_out.size() - base), 32'd2);
    if (fr_out.size() >= base + 2) begin
      check("fr_after_bad_b0", 32'(fr_out[base]), 32'({1'b1, 1'b0, 8'h41}));
      check("fr_after_bad_b1", 32'(fr_out[base+1]), 32'({1'b0, 1'b1, 8'h42}));
    end
    check("fr_bad_once", 32'(bad_cnt - bad0), 32'd1);

    // Frame mode random: short frames, consumer always ready, random bad markers
    base = fr_out.size();
    ovf0 = ovf_cnt; bad0 = bad_cnt; good0 = good_cnt;
    nbad = 0; ngood = 0;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 3);
      isbad = ($urandom_range(0, 2) == 0);
      frame.delete();
      for (int b = 0; b < len; b++) begin
        d = 8'($urandom);
        l = (b == len - 1);
        u = l ? isbad : 1'($urandom);
        if ($urandom_range(0, 1) != 0) tick();
        send_fr(d, l, u);
        frame.push_back({u, l, d});
      end
      if (isbad) nbad++;
      else begin
        ngood++;
        foreach (frame[k]) exp_fr.push_back(frame[k]);
      end
    end
    for (int n = 0; n < 20; n++) tick();
    check("fr_rand_count", 32'(fr_out.size() - base), 32'(exp_fr.size()));
    for (int i = 0; i < exp_fr.size() && base + i < fr_out.size(); i++)
      check("fr_rand_beat", 32'(fr_out[base+i]), 32'(exp_fr[i]));
    check("fr_rand_good", 32'(good_cnt - good0), 32'(ngood));
    check("fr_rand_bad", 32'(bad_cnt - bad0), 32'(nbad));
    check("fr_rand_ovf", 32'(ovf_cnt - ovf0), 32'd0);

    // Reset mid-frame discards everything, including the output register
    m_fr.tready = 1'b0;
    send_fr(8'h51, 1'b1, 1'b0);
    send_fr(8'h52, 1'b1, 1'b0);
    send_fr(8'h53, 1'b0, 1'b0);
    tick();
    check("rst_mid_holding", 32'(m_fr.tvalid), 32'd1);
    rst = 1'b0;
    tick();
    check("rst_mid_fr_tvalid", 32'(m_fr.tvalid), 32'd0);
    check("rst_mid_fr_tready", 32'(s_fr.tready), 32'd1);
    check("rst_mid_nf_tvalid", 32'(m_nf.tvalid), 32'd0);
    rst = 1'b1;
    m_fr.tready = 1'b1;
    base2 = fr_out.size();
    for (int n = 0; n < 6; n++) tick();
    check("rst_mid_empty", 32'(fr_out.size() - base2), 32'd0);
    send_fr(8'h61, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) tick();
    check("rst_mid_next_count", 32'(fr_out.size() - base2), 32'd1);
    if (fr_out.size() > base2)
      check("rst_mid_next_beat", 32'(fr_out[base2]), 32'({1'b0, 1'b1, 8'h61}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_frame_fifo.md
# axis_frame_fifo

AXI4-Stream FIFO with optional frame (store-and-forward) mode, built on a 2^ADDR_WIDTH-word RAM plus a one-word output register. In frame mode, a frame becomes visible on the master side only after its tlast beat is accepted. Frames that cannot fit, or that carry a bad-frame tuser marker, are discarded whole. It sits between an AXI-Stream producer and consumer as an elastic or packet buffer.

## Interface
- ADDR_WIDTH, 12: log2 of RAM depth in words.
- DATA_WIDTH, 8: tdata width.
- KEEP_ENABLE, (DATA_WIDTH>8): store tkeep.
- KEEP_WIDTH, (DATA_WIDTH/8): tkeep width.
- LAST_ENABLE, 1: store tlast.
- ID_ENABLE, 0 / ID_WIDTH, 8: store tid.
- DEST_ENABLE, 0 / DEST_WIDTH, 8: store tdest.
- USER_ENABLE, 1 / USER_WIDTH, 1: store tuser.
- FRAME_FIFO, 0: enable frame mode.
- USER_BAD_FRAME_VALUE, 1'b1 / USER_BAD_FRAME_MASK, 1'b1: tuser on the tlast beat marks a bad frame when (tuser & MASK) == (VALUE & MASK).
- DROP_BAD_FRAME, 0: discard bad frames (frame mode only).
- DROP_WHEN_FULL, 0: in frame mode, keep tready high and discard frames that overflow.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- s_axis_tdata/tkeep/tvalid/tready(out)/tlast/tid/tdest/tuser  in  per parameters  AXI-Stream slave.
- m_axis_tdata/tkeep/tvalid/tready(in)/tlast/tid/tdest/tuser  out  per parameters  AXI-Stream master.
- status_overflow  out  1  one-cycle pulse when a frame is dropped for lack of space.
- status_bad_frame  out  1  one-cycle pulse when a bad frame is dropped.
- status_good_frame  out  1  one-cycle pulse when a frame is committed.

## Operation
- Pointers are ADDR_WIDTH+1 bits: wr_ptr (committed), wr_ptr_cur (speculative write), rd_ptr.
- Status flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr == rd_ptr with MSB inverted).
  - full_cur = the same full test applied to wr_ptr_cur.
- Each RAM word holds data, then keep/last/id/dest/user, each only if enabled.
- Disabled fields drive fixed output values: tkeep all ones, tlast 1, tid/tdest/tuser 0.
- s_axis_tready:
  - non-frame mode: !full.
  - frame mode: !full_cur || DROP_WHEN_FULL.
- Non-frame mode: on an accepted beat, write RAM[wr_ptr] and increment wr_ptr and wr_ptr_cur.
- Frame mode, accepted beat while full_cur or drop_frame is set:
  - the beat is discarded and drop_frame is set.
  - on tlast: wr_ptr_cur <= wr_ptr, drop_frame clears, status_overflow pulses.
  - every beat of a dropped frame is discarded, including beats written before the overflow.
- Frame mode, accepted beat otherwise:
  - write RAM[wr_ptr_cur]; wr_ptr_cur increments.
  - on tlast with DROP_BAD_FRAME and a bad tuser: wr_ptr_cur <= wr_ptr; status_bad_frame pulses.
  - on any other tlast: wr_ptr <= wr_ptr_cur+1; status_good_frame pulses.
- Read side:
  - The output register loads RAM[rd_ptr] and rd_ptr increments when !empty && (!m_axis_tvalid || m_axis_tready).
  - m_axis_tvalid <= 1 on load.
  - m_axis_tvalid <= 0 when m_axis_tready is high and nothing is loaded.
- Total storage is 2^ADDR_WIDTH RAM words plus one word in the output register.

## Timing
- Reset (rst=0 at a clock edge): all pointers 0, drop_frame 0, m_axis_tvalid 0, all status outputs 0.
- Output data registers are don't-care after reset; they are driven 0 in this design.
- Non-frame mode: a beat accepted at edge N is valid on m_axis at edge N+1 if the output register is free.
- Frame mode: a frame's first beat appears on m_axis one edge after its tlast beat is accepted.
- Output register holding with m_axis_tready low: m_axis outputs are stable and no RAM read occurs.
- Simultaneous read and write in the same cycle are both allowed.
- full and empty are computed from registered pointers only, with no bypass.
- Pointer wrap uses the natural ADDR_WIDTH+1-bit overflow.
- Status pulses last exactly one cycle, the cycle after the causing beat.
- Reset mid-frame discards all contents, including partial frames and the output register.

## Test plan
- Non-frame mode, write 0..3 with m_tready=0 then m_tready=1 -> output 0,1,2,3 in order, tlast preserved, no gaps.
- Frame mode (ADDR_WIDTH=2, DROP_WHEN_FULL=1), sequence below -> all four single-beat frames are read as 1,1,2,3; data 4/5/6 never appear on m_axis_tdata; status_overflow pulses once:
  - m_tready=0.
  - frames {1}, {1}, {2}, {3} each tlast=1.
  - then beats 4, 5, 6 with tlast=0.
  - then m_tready=1 with valid continuing, tlast=1 on a later beat.
- Frame mode, 3-beat frame with tlast withheld -> m_axis_tvalid stays 0; after tlast, 3 beats are read and status_good_frame pulses.
- DROP_BAD_FRAME=1, frame ending with tuser=1 -> status_bad_frame pulses, nothing output; the next good frame passes.
- Non-frame, fill 5 words with m_tready=0 -> s_axis_tready drops after the 5th accept and recovers after one read.
- Assert rst=0 mid-frame -> m_axis_tvalid=0 next cycle, FIFO empty, s_axis_tready=1.
